// File: rtl/ex_pkg.sv
// Shared constants for the EX-stage ALU / branch unit: ALU op codes and
// the branch opcode/rt encodings decoded by the condition handler.
package ex_pkg;

    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned RT_W     = 5;
    localparam int unsigned NPC_STEP = 4;
    localparam int unsigned B_BIAS   = 8;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1010;
    localparam logic [ALU_OP_W-1:0] ALU_A    = 4'b1011;
    localparam logic [ALU_OP_W-1:0] ALU_B    = 4'b1100;
    localparam logic [ALU_OP_W-1:0] ALU_B8   = 4'b1101;

    localparam logic [OPCODE_W-1:0] OP_REGIMM = 6'b000001;
    localparam logic [OPCODE_W-1:0] OP_BEQ    = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE    = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_BLEZ   = 6'b000110;
    localparam logic [OPCODE_W-1:0] OP_BGTZ   = 6'b000111;

    localparam logic [RT_W-1:0] RT_BLTZ   = 5'b00000;
    localparam logic [RT_W-1:0] RT_BGEZ   = 5'b00001;
    localparam logic [RT_W-1:0] RT_BLTZAL = 5'b10000;
    localparam logic [RT_W-1:0] RT_BGEZAL = 5'b10001;

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU: result plus zero/negative flags of that result.
module alu_core
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH-1:0]    out_c,
    output logic                z_c,
    output logic                n_c
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

    // Operation select; unused codes produce zero.
    always_comb begin
        out_c = '0;
        case (op)
            ALU_ADD:  out_c = a + b;
            ALU_SUB:  out_c = a - b;
            ALU_AND:  out_c = a & b;
            ALU_OR:   out_c = a | b;
            ALU_XOR:  out_c = a ^ b;
            ALU_NOR:  out_c = ~(a | b);
            ALU_SLL:  out_c = a << shamt;
            ALU_SRL:  out_c = a >> shamt;
            ALU_SRA:  out_c = WIDTH'($signed(a) >>> shamt);
            ALU_SLT:  out_c = WIDTH'($signed(a) < $signed(b));
            ALU_SLTU: out_c = WIDTH'(a < b);
            ALU_A:    out_c = a;
            ALU_B:    out_c = b;
            ALU_B8:   out_c = b + WIDTH'(B_BIAS);
            default:  out_c = '0;
        endcase
    end

    assign z_c = (out_c == '0);
    assign n_c = out_c[WIDTH-1];

endmodule

// File: rtl/ex_alu_branch_unit.sv
// EX-stage arithmetic block: ALU, nPC+4 incrementer and branch condition,
// all results captured in one output register stage.
module ex_alu_branch_unit
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [WIDTH-1:0]    npc_in,
    input  logic                b_instr,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [RT_W-1:0]     rt,
    output logic [WIDTH-1:0]    alu_out,
    output logic                z,
    output logic                n,
    output logic [WIDTH-1:0]    npc_plus4,
    output logic                cond_true
);

    logic [WIDTH-1:0] alu_res_c;
    logic             z_c;
    logic             n_c;
    logic [WIDTH-1:0] npc_sum_c;
    logic             taken_c;
    logic             cond_c;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op    (alu_op),
        .a     (a),
        .b     (b),
        .out_c (alu_res_c),
        .z_c   (z_c),
        .n_c   (n_c)
    );

    always_comb begin
        npc_sum_c = npc_in + WIDTH'(NPC_STEP);
    end

    // Branch decision from this cycle's flags; unknown encodings never take.
    always_comb begin
        taken_c = 1'b0;
        case (opcode)
            OP_BEQ:  taken_c = z_c;
            OP_BNE:  taken_c = ~z_c;
            OP_BLEZ: taken_c = z_c | n_c;
            OP_BGTZ: taken_c = ~z_c & ~n_c;
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BLTZAL: taken_c = n_c;
                    RT_BGEZ, RT_BGEZAL: taken_c = ~n_c;
                    default:            taken_c = 1'b0;
                endcase
            end
            default: taken_c = 1'b0;
        endcase
        cond_c = b_instr & taken_c;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_out   <= '0;
            z         <= 1'b0;
            n         <= 1'b0;
            npc_plus4 <= '0;
            cond_true <= 1'b0;
        end else begin
            alu_out   <= alu_res_c;
            z         <= z_c;
            n         <= n_c;
            npc_plus4 <= npc_sum_c;
            cond_true <= cond_c;
        end
    end

endmodule

// File: tb/tb_ex_alu_branch_unit.sv
// Self-checking bench for ex_alu_branch_unit: directed cases plus random
// operands compared against an arithmetic reference model.
module tb_ex_alu_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] npc_in;
    logic        b_instr;
    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [31:0] alu_out;
    logic        z;
    logic        n;
    logic [31:0] npc_plus4;
    logic        cond_true;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_alu_branch_unit #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .npc_in    (npc_in),
        .b_instr   (b_instr),
        .opcode    (opcode),
        .rt        (rt),
        .alu_out   (alu_out),
        .z         (z),
        .n         (n),
        .npc_plus4 (npc_plus4),
        .cond_true (cond_true)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference ALU in plain arithmetic (shifts as powers of two).
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        longint unsigned ux;
        longint unsigned pw;
        longint          sx;
        int unsigned     sh;
        ux = longint'(x);
        sh = y % 32;
        pw = 64'd1 << sh;
        sx = longint'($signed(x));
        case (op)
            4'd0:  return 32'(ux + longint'(y));
            4'd1:  return 32'(ux + 64'h1_0000_0000 - longint'(y));
            4'd2:  return x & y;
            4'd3:  return x | y;
            4'd4:  return x ^ y;
            4'd5:  return ~(x | y);
            4'd6:  return 32'(ux * pw);
            4'd7:  return 32'(ux / pw);
            4'd8:  return (sx >= 0) ? 32'(sx / longint'(pw))
                                    : 32'(-((-sx + longint'(pw) - 1) / longint'(pw)));
            4'd9:  return (sx < longint'($signed(y))) ? 32'd1 : 32'd0;
            4'd10: return (ux < longint'(y)) ? 32'd1 : 32'd0;
            4'd11: return x;
            4'd12: return y;
            4'd13: return 32'(longint'(y) + 8);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic bi, input logic [5:0] opc, input logic [4:0] rtv,
                                      input logic [31:0] res);
        bit zz;
        bit nn;
        bit c;
        zz = (res == 32'd0);
        nn = ($signed(res) < 0);
        case (opc)
            6'd4: c = zz;
            6'd5: c = !zz;
            6'd6: c = zz || nn;
            6'd7: c = !zz && !nn;
            6'd1: begin
                if (rtv == 5'd0 || rtv == 5'd16)      c = nn;
                else if (rtv == 5'd1 || rtv == 5'd17) c = !nn;
                else                                  c = 1'b0;
            end
            default: c = 1'b0;
        endcase
        return bi && c;
    endfunction

    // Drive one cycle of inputs, let the edge capture them, then compare.
    task automatic apply(input string tag, input logic rst, input logic [3:0] op,
                         input logic [31:0] x, input logic [31:0] y, input logic [31:0] pc,
                         input logic bi, input logic [5:0] opc, input logic [4:0] rtv);
        logic [31:0] er;
        logic [31:0] ep;
        logic        ec;
        reset   = rst;
        alu_op  = op;
        a       = x;
        b       = y;
        npc_in  = pc;
        b_instr = bi;
        opcode  = opc;
        rt      = rtv;
        @(posedge clk);
        #1;
        if (!rst) begin
            er = 32'd0;
            ep = 32'd0;
            ec = 1'b0;
        end else begin
            er = ref_alu(op, x, y);
            ep = 32'(longint'(pc) + 4);
            ec = ref_cond(bi, opc, rtv, er);
        end
        check({tag, ".alu_out"}, alu_out, er);
        check({tag, ".z"}, 32'(z), (rst && er == 32'd0) ? 32'd1 : 32'd0);
        check({tag, ".n"}, 32'(n), (rst && er >= 32'h8000_0000) ? 32'd1 : 32'd0);
        check({tag, ".npc_plus4"}, npc_plus4, ep);
        check({tag, ".cond_true"}, 32'(cond_true), 32'(ec));
    endtask

    // Explicit expectations from hand-derived values.
    task automatic expect_vals(input string tag, input logic [31:0] er, input logic ez,
                               input logic ec);
        check({tag, ".exp_alu"}, alu_out, er);
        check({tag, ".exp_z"}, 32'(z), 32'(ez));
        check({tag, ".exp_cond"}, 32'(cond_true), 32'(ec));
    endtask

    logic [5:0] opc_pool [8];
    logic [4:0] rt_pool  [6];

    initial begin
        opc_pool = '{6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd0, 6'd35};
        rt_pool  = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd2, 5'd31};

        // Reset with arbitrary inputs.
        apply("rst0", 1'b0, 4'd0, $urandom, $urandom, $urandom, 1'b1, 6'd4, 5'd0);
        apply("rst1", 1'b0, 4'd1, $urandom, $urandom, $urandom, 1'b1, 6'd5, 5'd0);
        apply("rel", 1'b1, 4'd0, 32'd0, 32'd0, 32'h0000_0000, 1'b0, 6'd0, 5'd0);
        check("rel.npc4", npc_plus4, 32'd4);

        apply("sub_eq", 1'b1, 4'd1, 32'd5, 32'd5, 32'd100, 1'b0, 6'd0, 5'd0);
        expect_vals("sub_eq", 32'd0, 1'b1, 1'b0);
        apply("sub_neg", 1'b1, 4'd1, 32'd3, 32'd5, 32'd100, 1'b0, 6'd0, 5'd0);
        expect_vals("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0);
        check("sub_neg.n", 32'(n), 32'd1);
        apply("sra", 1'b1, 4'd8, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 6'd0, 5'd0);
        expect_vals("sra", 32'hF800_0000, 1'b0, 1'b0);
        apply("srl", 1'b1, 4'd7, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 6'd0, 5'd0);
        expect_vals("srl", 32'h0800_0000, 1'b0, 1'b0);
        apply("b8", 1'b1, 4'd13, 32'd0, 32'h100, 32'd0, 1'b0, 6'd0, 5'd0);
        expect_vals("b8", 32'h108, 1'b0, 1'b0);
        apply("sltu", 1'b1, 4'd10, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 6'd0, 5'd0);
        expect_vals("sltu", 32'd0, 1'b1, 1'b0);
        apply("slt", 1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 6'd0, 5'd0);
        expect_vals("slt", 32'd1, 1'b0, 1'b0);
        apply("bgtz_t", 1'b1, 4'd1, 32'd7, 32'd0, 32'd0, 1'b1, 6'd7, 5'd0);
        expect_vals("bgtz_t", 32'd7, 1'b0, 1'b1);
        apply("bgtz_nt", 1'b1, 4'd1, 32'd0, 32'd0, 32'd0, 1'b1, 6'd7, 5'd0);
        expect_vals("bgtz_nt", 32'd0, 1'b1, 1'b0);
        apply("bltzal", 1'b1, 4'd1, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 6'd1, 5'd16);
        expect_vals("bltzal", 32'h8000_0000, 1'b0, 1'b1);
        apply("beq_nb", 1'b1, 4'd1, 32'd9, 32'd9, 32'd0, 1'b0, 6'd4, 5'd0);
        expect_vals("beq_nb", 32'd0, 1'b1, 1'b0);
        apply("beq_b", 1'b1, 4'd1, 32'd9, 32'd9, 32'd0, 1'b1, 6'd4, 5'd0);
        expect_vals("beq_b", 32'd0, 1'b1, 1'b1);
        apply("wrap_pc", 1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 1'b0, 6'd0, 5'd0);
        expect_vals("wrap_add", 32'd0, 1'b1, 1'b0);
        check("wrap_pc.npc4", npc_plus4, 32'd0);

        // Reset mid-stream drops the in-flight result.
        apply("mid_a", 1'b1, 4'd11, 32'h1234_5678, 32'd0, 32'h40, 1'b1, 6'd5, 5'd0);
        apply("mid_rst", 1'b0, 4'd11, 32'hDEAD_BEEF, 32'd0, 32'h44, 1'b1, 6'd5, 5'd0);
        apply("mid_b", 1'b1, 4'd12, 32'd0, 32'hCAFE_0000, 32'h48, 1'b1, 6'd1, 5'd1);

        // Random stream, with branch encodings favoured and occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = ra;
                2: ra = {ra[31], 31'($urandom_range(0, 3))};
                default: ;
            endcase
            apply($sformatf("rnd%0d", i), ($urandom_range(0, 19) != 0),
                  4'($urandom_range(0, 15)), ra, rb, $urandom,
                  1'($urandom_range(0, 1)), opc_pool[$urandom_range(0, 7)],
                  rt_pool[$urandom_range(0, 5)]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
